// File: rtl/simon_pkg.sv
// Shared types for the Simon game: button codes used by the input stage
// and by the game core's sequence memory.
package simon_pkg;

    typedef enum logic [1:0] {BTN_A, BTN_B, BTN_C, BTN_D} btn_code_t;

    localparam int NUM_BUTTONS = 4;

    // Index of the highest set bit, used on a vector already known to be one-hot.
    function automatic btn_code_t code_of(input logic [NUM_BUTTONS-1:0] v);
        btn_code_t c;
        c = BTN_A;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (v[i]) begin
                c = btn_code_t'(i[1:0]);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/button_event_unit_if.sv
// Valid/ready event stream carrying button codes from the input stage
// to the game FSM.
interface button_event_unit_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/debounce_cell.sv
// One push-button: two-flop synchroniser followed by a counter that only
// lets the stable level flip after the input has disagreed with it for a
// full debounce period.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic [CW-1:0] r_count;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    // Any agreement restarts the count, so short glitches never flip the level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_stable <= 1'b0;
        end else if (r_sync == r_stable) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_stable <= r_sync;
            r_count  <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/button_event_unit.sv
// Input stage for the Simon core: debounces the four buttons, turns each
// clean single press into a button code and queues it in a small
// show-ahead FIFO read through a valid/ready handshake.
module button_event_unit
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] async_buttons,
    input  logic                   clear,
    button_event_unit_if.master    evt,
    output logic [NUM_BUTTONS-1:0] pressed_level,
    output logic                   multi_press_err,
    output logic                   overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BUTTONS-1:0] w_stable;
    logic [NUM_BUTTONS-1:0] r_stable_d;
    logic [NUM_BUTTONS-1:0] w_rise;
    logic [NUM_BUTTONS-1:0] w_others;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    btn_code_t              r_mem [FIFO_DEPTH];
    logic                   r_err;
    logic                   r_overflow;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_cell
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_async  (async_buttons[g]),
            .o_stable (w_stable[g])
        );
    end

    // Previous stable levels, for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    // A press counts only if it is the sole rise and nothing else is held.
    assign w_rise   = w_stable & ~r_stable_d;
    assign w_others = w_stable & ~w_rise;
    assign w_accept = ($countones(w_rise) == 1) && (w_others == '0);
    assign w_reject = (w_rise != '0) && !w_accept;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && evt.evt_ready && !clear;
    assign w_push  = w_accept && (!w_full || w_pop) && !clear;
    assign w_drop  = w_accept && w_full && !w_pop && !clear;

    // Rejected presses raise a one-cycle error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    // Event queue; clear wins over any coinciding push or pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= BTN_A;
            end
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= code_of(w_rise);
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign evt.evt_valid   = !w_empty;
    assign evt.evt_code    = r_mem[r_rd_ptr[AW-1:0]];
    assign pressed_level   = w_stable;
    assign multi_press_err = r_err;
    assign overflow        = r_overflow;

endmodule
